// File: rtl/nes_pkg.sv
// Shared definitions for the NES button event block: button bit indices,
// the button vector type and the auto-repeat FSM state encoding.
package nes_pkg;

    localparam int NUM_BTNS = 8;
    localparam int NUM_DIRS = 4;

    localparam int BTN_A      = 7;
    localparam int BTN_B      = 6;
    localparam int BTN_SELECT = 5;
    localparam int BTN_START  = 4;
    localparam int BTN_UP     = 3;
    localparam int BTN_DOWN   = 2;
    localparam int BTN_LEFT   = 1;
    localparam int BTN_RIGHT  = 0;

    typedef logic [NUM_BTNS-1:0] btn_vec_t;

    typedef enum logic [1:0] {
        RPT_IDLE   = 2'd0,
        RPT_DELAY  = 2'd1,
        RPT_REPEAT = 2'd2
    } rpt_state_t;

    // Counter width for a count of n cycles; never narrower than one bit.
    function automatic int cnt_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/nes_debounce.sv
// One button bit: 2-flop synchronizer, stability counter, debounced level
// and registered press/release strobes aligned with the level change.
module nes_debounce
    import nes_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 200000
) (
    input  logic clk,
    input  logic reset,
    input  logic btn_raw,
    output logic state,
    output logic press_pulse,
    output logic release_pulse
);

    localparam int CW = cnt_width(DEBOUNCE_CYCLES);
    localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);

    logic          sync1;
    logic          sync2;
    logic [CW-1:0] cnt;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync1         <= 1'b0;
            sync2         <= 1'b0;
            cnt           <= '0;
            state         <= 1'b0;
            press_pulse   <= 1'b0;
            release_pulse <= 1'b0;
        end else begin
            sync1         <= btn_raw;
            sync2         <= sync1;
            press_pulse   <= 1'b0;
            release_pulse <= 1'b0;
            if (sync2 == state) begin
                cnt <= '0;
            end else if (cnt == CNT_MAX) begin
                // Stable long enough: accept the new level and strobe its edge.
                cnt           <= '0;
                state         <= sync2;
                press_pulse   <= sync2;
                release_pulse <= ~sync2;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/nes_button_events.sv
// Debounced NES button levels with press/release strobes and optional
// direction auto-repeat, enabled by defining NES_AUTOREPEAT_EN.
module nes_button_events
    import nes_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 200000,
    parameter int REPEAT_DELAY    = 40000000,
    parameter int REPEAT_PERIOD   = 10000000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] btn_in,
    output logic [7:0] btn_state,
    output logic [7:0] press_pulse,
    output logic [7:0] release_pulse,
    output logic [3:0] repeat_pulse
);

    for (genvar b = 0; b < NUM_BTNS; b++) begin : gen_btn
        nes_debounce #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
        ) u_debounce (
            .clk          (clk),
            .reset        (reset),
            .btn_raw      (btn_in[b]),
            .state        (btn_state[b]),
            .press_pulse  (press_pulse[b]),
            .release_pulse(release_pulse[b])
        );
    end

`ifdef NES_AUTOREPEAT_EN
    localparam int RPT_SPAN = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
    localparam int RW       = cnt_width(RPT_SPAN);
    localparam logic [RW-1:0] DELAY_MAX  = RW'(REPEAT_DELAY - 1);
    localparam logic [RW-1:0] PERIOD_MAX = RW'(REPEAT_PERIOD - 1);

    for (genvar d = 0; d < NUM_DIRS; d++) begin : gen_rpt
        rpt_state_t    state_q;
        rpt_state_t    state_n;
        logic [RW-1:0] cnt_q;
        logic [RW-1:0] cnt_n;
        logic          pulse;

        always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
                state_q <= RPT_IDLE;
                cnt_q   <= '0;
            end else begin
                state_q <= state_n;
                cnt_q   <= cnt_n;
            end
        end

        // Release is checked first so no repeat strobe fires in the release cycle.
        always_comb begin
            state_n = state_q;
            cnt_n   = cnt_q;
            pulse   = 1'b0;
            case (state_q)
                RPT_IDLE: begin
                    if (press_pulse[d]) begin
                        state_n = RPT_DELAY;
                        cnt_n   = '0;
                    end
                end
                RPT_DELAY: begin
                    if (!btn_state[d]) begin
                        state_n = RPT_IDLE;
                        cnt_n   = '0;
                    end else if (cnt_q == DELAY_MAX) begin
                        pulse   = 1'b1;
                        state_n = RPT_REPEAT;
                        cnt_n   = '0;
                    end else begin
                        cnt_n = cnt_q + 1'b1;
                    end
                end
                RPT_REPEAT: begin
                    if (!btn_state[d]) begin
                        state_n = RPT_IDLE;
                        cnt_n   = '0;
                    end else if (cnt_q == PERIOD_MAX) begin
                        pulse = 1'b1;
                        cnt_n = '0;
                    end else begin
                        cnt_n = cnt_q + 1'b1;
                    end
                end
                default: begin
                    state_n = RPT_IDLE;
                    cnt_n   = '0;
                end
            endcase
        end

        assign repeat_pulse[d] = pulse;
    end
`else
    logic unused_repeat_cfg;
    assign unused_repeat_cfg = (REPEAT_DELAY > REPEAT_PERIOD);
    assign repeat_pulse      = 4'b0000;
`endif

endmodule

// File: tb/tb_nes_button_events.sv
// Bench for nes_button_events with short debounce/repeat parameters; the
// expected trace of every cycle is queued when stimulus is applied.
module tb_nes_button_events;

    localparam int DB  = 4;
    localparam int RD  = 10;
    localparam int RP  = 3;
    localparam int LAT = 2 + DB;

    logic       clk    = 1'b0;
    logic       reset  = 1'b1;
    logic [7:0] btn_in = 8'h00;
    logic [7:0] btn_state;
    logic [7:0] press_pulse;
    logic [7:0] release_pulse;
    logic [3:0] repeat_pulse;

    int checks = 0;
    int errors = 0;

    logic [27:0] exp_q[$];
    logic        sb_on = 1'b0;
    string       sb_tag = "";
    int          sb_cycle = 0;
    int          press_seen = 0;
    int          rep_seen = 0;
    logic [27:0] mon_act;
    logic [27:0] mon_exp;

    nes_button_events #(
        .DEBOUNCE_CYCLES(DB),
        .REPEAT_DELAY   (RD),
        .REPEAT_PERIOD  (RP)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .btn_in       (btn_in),
        .btn_state    (btn_state),
        .press_pulse  (press_pulse),
        .release_pulse(release_pulse),
        .repeat_pulse (repeat_pulse)
    );

    always #5 clk = ~clk;

    // Expected {state, press, release, repeat} at sample i (i-th edge after
    // btn_in goes to bits), with btn_in returning to 0 after `hold` edges.
    function automatic logic [27:0] model_vec(input logic [7:0] bits, input int hold, input int i);
        logic [7:0] st;
        logic [7:0] pr;
        logic [7:0] rl;
        logic [3:0] rp;
        int         rel;
        st = '0;
        pr = '0;
        rl = '0;
        rp = '0;
        if (hold >= DB) begin
            rel = hold + LAT;
            if (i >= LAT && i < rel) st = bits;
            if (i == LAT) pr = bits;
            if (i == rel) rl = bits;
`ifdef NES_AUTOREPEAT_EN
            if (i >= LAT + RD && i < rel && ((i - LAT - RD) % RP) == 0) rp = bits[3:0];
`endif
        end
        return {st, pr, rl, rp};
    endfunction

    // Scoreboard: pops one expected vector per active cycle.
    always @(posedge clk) begin
        if (sb_on) begin
            #1;
            sb_cycle++;
            mon_act = {btn_state, press_pulse, release_pulse, repeat_pulse};
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL %s_queue cycle %0d: got %h with no expected entry", sb_tag, sb_cycle, mon_act);
            end else begin
                mon_exp = exp_q.pop_front();
                if (mon_act !== mon_exp) begin
                    errors++;
                    $display("FAIL %s cycle %0d: state=%h press=%h release=%h repeat=%h, expected state=%h press=%h release=%h repeat=%h",
                             sb_tag, sb_cycle, mon_act[27:20], mon_act[19:12], mon_act[11:4], mon_act[3:0],
                             mon_exp[27:20], mon_exp[19:12], mon_exp[11:4], mon_exp[3:0]);
                end
            end
            press_seen += $countones(press_pulse);
            rep_seen   += $countones(repeat_pulse);
        end
    end

    // Called just after a rising edge; returns 2 time units after the n-th edge.
    task automatic drive_hold(input string tag, input logic [7:0] bits, input int hold, input int n);
        for (int i = 1; i <= n; i++) exp_q.push_back(model_vec(bits, hold, i));
        sb_tag     = tag;
        sb_cycle   = 0;
        press_seen = 0;
        rep_seen   = 0;
        btn_in     = bits;
        sb_on      = 1'b1;
        for (int i = 1; i <= n; i++) begin
            @(posedge clk);
            #2;
            if (i == hold) btn_in = 8'h00;
        end
        sb_on = 1'b0;
    endtask

    task automatic test_reset;
        reset  = 1'b1;
        btn_in = 8'h00;
        repeat (3) @(posedge clk);
        #2;
        checks++;
        if (btn_state !== 8'h00) begin errors++; $display("FAIL reset_state: got %h want 00", btn_state); end
        checks++;
        if (press_pulse !== 8'h00) begin errors++; $display("FAIL reset_press: got %h want 00", press_pulse); end
        checks++;
        if (release_pulse !== 8'h00) begin errors++; $display("FAIL reset_release: got %h want 00", release_pulse); end
        checks++;
        if (repeat_pulse !== 4'h0) begin errors++; $display("FAIL reset_repeat: got %h want 0", repeat_pulse); end
        reset = 1'b0;
        @(posedge clk);
        #2;
    endtask

    task automatic check_counts(input string tag, input int press_exp, input int rep_exp);
        checks++;
        if (exp_q.size() != 0) begin errors++; $display("FAIL %s_drain: %0d entries left want 0", tag, exp_q.size()); end
        checks++;
        if (press_seen != press_exp) begin errors++; $display("FAIL %s_press_count: got %0d want %0d", tag, press_seen, press_exp); end
        checks++;
        if (rep_seen != rep_exp) begin errors++; $display("FAIL %s_repeat_count: got %0d want %0d", tag, rep_seen, rep_exp); end
    endtask

    task automatic test_press_release;
        int hold;
        hold = $urandom_range(6, 12);
        drive_hold("press_release_a", 8'h80, hold, hold + LAT + 3);
        check_counts("press_release_a", 1, 0);
    endtask

    task automatic test_glitch;
        drive_hold("glitch_b", 8'h40, DB - 1, 14);
        check_counts("glitch_b", 0, 0);
    endtask

    task automatic test_debounce_boundary;
        drive_hold("boundary_select", 8'h20, DB, DB + LAT + 4);
        check_counts("boundary_select", 1, 0);
    endtask

    task automatic test_repeat;
        int rep_exp;
        rep_exp = 0;
`ifdef NES_AUTOREPEAT_EN
        rep_exp = 10;
`endif
        drive_hold("repeat_up", 8'h08, 40, 52);
        check_counts("repeat_up", 1, rep_exp);
        drive_hold("repeat_right", 8'h01, 40, 52);
        check_counts("repeat_right", 1, rep_exp);
    endtask

    task automatic test_simultaneous;
        int rep_exp;
        rep_exp = 0;
`ifdef NES_AUTOREPEAT_EN
        rep_exp = 20;
`endif
        drive_hold("simul_dirs", 8'h0F, 25, 36);
        check_counts("simul_dirs", 4, rep_exp);
    endtask

    task automatic test_back_to_back;
        drive_hold("b2b_start_1", 8'h10, 6, 14);
        drive_hold("b2b_start_2", 8'h10, 6, 14);
        check_counts("b2b_start_2", 1, 0);
    endtask

    task automatic test_reset_mid;
        int rep_exp;
        rep_exp = 0;
`ifdef NES_AUTOREPEAT_EN
        rep_exp = 20;
`endif
        drive_hold("pre_reset", 8'hFF, 100, 8);
        #1;
        reset = 1'b1;
        #1;
        checks++;
        if (btn_state !== 8'h00) begin errors++; $display("FAIL midreset_state: got %h want 00", btn_state); end
        checks++;
        if (press_pulse !== 8'h00) begin errors++; $display("FAIL midreset_press: got %h want 00", press_pulse); end
        checks++;
        if (release_pulse !== 8'h00) begin errors++; $display("FAIL midreset_release: got %h want 00", release_pulse); end
        checks++;
        if (repeat_pulse !== 4'h0) begin errors++; $display("FAIL midreset_repeat: got %h want 0", repeat_pulse); end
        repeat (2) @(posedge clk);
        #2;
        reset = 1'b0;
        drive_hold("post_reset", 8'hFF, 25, 36);
        check_counts("post_reset", 8, rep_exp);
    endtask

    initial begin
        test_reset;
        test_press_release;
        test_glitch;
        test_debounce_boundary;
        test_repeat;
        test_simultaneous;
        test_back_to_back;
        test_reset_mid;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
